// File: rtl/ml_accel_pkg.sv
// ---------------------------------------------------------------------------
// ml_accel_pkg : shared encodings for the ML accelerator host controller (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package ml_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ARM    = 3'd3,
    ST_RUN    = 3'd4,
    ST_RETIRE = 3'd5,
    ST_REPORT = 3'd6
  } host_state_t;

  localparam logic [1:0] CPL_OK   = 2'b00;
  localparam logic [1:0] CPL_TMO  = 2'b01;
  localparam logic [1:0] CPL_ZLEN = 2'b10;

  // Accelerator-side control FSM codes, mirrored here so benches can name them
  localparam logic [1:0] ACC_IDLE = 2'd0;
  localparam logic [1:0] ACC_BUSY = 2'd1;
  localparam logic [1:0] ACC_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ml_accel_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// ml_accel_host_ctrl_if : command, source, buffer, accelerator and completion bus (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface ml_accel_host_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ready;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              buf_we;
  logic [LEN_W-1:0]  buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              accel_start;
  logic              accel_data_ready;
  logic              accel_ack;
  logic              accel_busy;
  logic              accel_idle;
  logic              cpl_valid;
  logic [1:0]        cpl_status;
  logic              cpl_ready;
  logic              err_timeout;

  modport master (
    input  cmd_valid, cmd_len, src_valid, src_data, accel_busy, accel_idle, cpl_ready,
    output cmd_ready, src_ready, buf_we, buf_addr, buf_wdata,
           accel_start, accel_data_ready, accel_ack, cpl_valid, cpl_status, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_len, src_valid, src_data, accel_busy, accel_idle, cpl_ready,
    input  cmd_ready, src_ready, buf_we, buf_addr, buf_wdata,
           accel_start, accel_data_ready, accel_ack, cpl_valid, cpl_status, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/ml_accel_tmo_cnt.sv
// ---------------------------------------------------------------------------
// ml_accel_tmo_cnt : clear/enable watchdog counter with expiry compare (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module ml_accel_tmo_cnt #(
  parameter int          TMO_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic clr,
  input  wire logic en,
  output logic      expired
);

  logic [TMO_W-1:0] tmo;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      tmo <= '0;
    end else if (en) begin
      tmo <= tmo + TMO_W'(1);
    end
  end

  assign expired = en && (tmo == TMO_W'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/ml_accel_host_ctrl.sv
// ---------------------------------------------------------------------------
// ml_accel_host_ctrl : launches a job, stages its input words and retires it (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module ml_accel_host_ctrl
  import ml_accel_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          LEN_W          = 8,
  parameter int          TMO_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  ml_accel_host_ctrl_if.master bus
);

  host_state_t      state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic             start_q;
  logic             load_q;
  logic             dready_q;
  logic             ack_q;
  logic             cpl_valid_q;
  logic [1:0]       status_q;
  logic             err_q;
  logic             hs;
  logic             tmo_en;
  logic             tmo_clr;
  logic             tmo_exp;

  assign hs      = load_q && bus.src_valid;
  assign tmo_en  = (state == ST_ARM) || (state == ST_RUN);
  // Re-arm the watchdog on the ARM->RUN hop so each phase gets a full budget
  assign tmo_clr = !tmo_en || ((state == ST_ARM) && bus.accel_busy);

  ml_accel_tmo_cnt #(
    .TMO_W          (TMO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      len         <= '0;
      cnt         <= '0;
      start_q     <= 1'b0;
      load_q      <= 1'b0;
      dready_q    <= 1'b0;
      ack_q       <= 1'b0;
      cpl_valid_q <= 1'b0;
      status_q    <= CPL_OK;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && bus.accel_idle) begin
            len <= bus.cmd_len;
            cnt <= '0;
            if (bus.cmd_len == '0) begin
              cpl_valid_q <= 1'b1;
              status_q    <= CPL_ZLEN;
              state       <= ST_REPORT;
            end else begin
              start_q <= 1'b1;
              state   <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          start_q <= 1'b0;
          load_q  <= 1'b1;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (hs) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len - LEN_W'(1)) begin
              load_q   <= 1'b0;
              dready_q <= 1'b1;
              state    <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (bus.accel_busy) begin
            dready_q <= 1'b0;
            state    <= ST_RUN;
          end else if (tmo_exp) begin
            dready_q    <= 1'b0;
            cpl_valid_q <= 1'b1;
            status_q    <= CPL_TMO;
            err_q       <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_RUN: begin
          if (!bus.accel_busy) begin
            ack_q <= 1'b1;
            state <= ST_RETIRE;
          end else if (tmo_exp) begin
            cpl_valid_q <= 1'b1;
            status_q    <= CPL_TMO;
            err_q       <= 1'b1;
            state       <= ST_REPORT;
          end
        end
        ST_RETIRE: begin
          if (bus.accel_idle) begin
            ack_q       <= 1'b0;
            cpl_valid_q <= 1'b1;
            status_q    <= CPL_OK;
            state       <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (bus.cpl_ready) begin
            cpl_valid_q <= 1'b0;
            status_q    <= CPL_OK;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready        = (state == ST_IDLE) && bus.accel_idle;
  assign bus.src_ready        = load_q;
  assign bus.buf_we           = hs;
  assign bus.buf_addr         = cnt;
  assign bus.buf_wdata        = load_q ? bus.src_data : {DATA_W{1'b0}};
  assign bus.accel_start      = start_q;
  assign bus.accel_data_ready = dready_q;
  assign bus.accel_ack        = ack_q;
  assign bus.cpl_valid        = cpl_valid_q;
  assign bus.cpl_status       = status_q;
  assign bus.err_timeout      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ml_accel_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ml_accel_host_ctrl : directed vector bench for the accelerator host controller (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ml_accel_host_ctrl;
  import ml_accel_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ml_accel_host_ctrl_if #(.DATA_W(32), .LEN_W(8)) bus ();

  ml_accel_host_ctrl #(
    .DATA_W         (32),
    .LEN_W          (8),
    .TMO_W          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // exp bit order: cmd_ready src_ready buf_we start data_ready ack cpl_valid status[1:0] err
  typedef struct {
    logic        cv;
    logic [7:0]  len;
    logic        sv;
    logic [31:0] sd;
    logic        busy;
    logic        idle;
    logic        cr;
    logic [9:0]  exp;
    logic [7:0]  eaddr;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.cmd_ready, bus.src_ready, bus.buf_we, bus.accel_start, bus.accel_data_ready,
            bus.accel_ack, bus.cpl_valid, bus.cpl_status, bus.err_timeout};
  endfunction

  task automatic drive(input logic cv, input logic [7:0] len, input logic sv, input logic [31:0] sd,
                       input logic busy, input logic idle, input logic cr);
    bus.cmd_valid  = cv;
    bus.cmd_len    = len;
    bus.src_valid  = sv;
    bus.src_data   = sd;
    bus.accel_busy = busy;
    bus.accel_idle = idle;
    bus.cpl_ready  = cr;
  endtask

  function automatic vec_t mk(input logic cv, input logic [7:0] len, input logic sv,
                              input logic [31:0] sd, input logic busy, input logic idle,
                              input logic cr, input logic [9:0] exp, input logic [7:0] eaddr);
    vec_t v;
    v.cv = cv; v.len = len; v.sv = sv; v.sd = sd; v.busy = busy;
    v.idle = idle; v.cr = cr; v.exp = exp; v.eaddr = eaddr;
    return v;
  endfunction

  initial begin
    logic [5:0] pat;
    int         nw;
    int         n;
    logic       done;

    // Normal len-4 job, busy for 6 cycles, then a zero-length reject held for 3 cycles
    vecs[0]  = mk(1, 8'd4, 0, 32'h0,  0, 1, 0, 10'b1000000000, 8'd0);
    vecs[1]  = mk(0, 8'd0, 1, 32'hA0, 0, 1, 0, 10'b0001000000, 8'd0);
    vecs[2]  = mk(0, 8'd0, 1, 32'hA0, 0, 0, 0, 10'b0110000000, 8'd0);
    vecs[3]  = mk(0, 8'd0, 1, 32'hA1, 0, 0, 0, 10'b0110000000, 8'd1);
    vecs[4]  = mk(0, 8'd0, 1, 32'hA2, 0, 0, 0, 10'b0110000000, 8'd2);
    vecs[5]  = mk(0, 8'd0, 1, 32'hA3, 0, 0, 0, 10'b0110000000, 8'd3);
    vecs[6]  = mk(0, 8'd0, 0, 32'h0,  0, 0, 0, 10'b0000100000, 8'd0);
    vecs[7]  = mk(0, 8'd0, 0, 32'h0,  1, 0, 0, 10'b0000100000, 8'd0);
    for (int i = 8; i <= 12; i++) vecs[i] = mk(0, 8'd0, 0, 32'h0, 1, 0, 0, 10'b0000000000, 8'd0);
    vecs[13] = mk(0, 8'd0, 0, 32'h0,  0, 0, 0, 10'b0000000000, 8'd0);
    vecs[14] = mk(0, 8'd0, 0, 32'h0,  0, 0, 0, 10'b0000010000, 8'd0);
    vecs[15] = mk(0, 8'd0, 0, 32'h0,  0, 1, 0, 10'b0000010000, 8'd0);
    vecs[16] = mk(0, 8'd0, 0, 32'h0,  0, 1, 1, 10'b0000001000, 8'd0);
    vecs[17] = mk(0, 8'd0, 0, 32'h0,  0, 1, 0, 10'b1000000000, 8'd0);
    vecs[18] = mk(1, 8'd0, 0, 32'h0,  0, 1, 0, 10'b1000000000, 8'd0);
    vecs[19] = mk(0, 8'd0, 0, 32'h0,  0, 1, 0, 10'b0000001100, 8'd0);
    vecs[20] = mk(0, 8'd0, 0, 32'h0,  0, 1, 0, 10'b0000001100, 8'd0);
    vecs[21] = mk(0, 8'd0, 0, 32'h0,  0, 1, 1, 10'b0000001100, 8'd0);
    vecs[22] = mk(0, 8'd0, 0, 32'h0,  0, 1, 0, 10'b1000000000, 8'd0);

    reset_n = 1'b0;
    drive(0, 8'd0, 0, 32'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_addr", 32'(bus.buf_addr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].cv, vecs[i].len, vecs[i].sv, vecs[i].sd, vecs[i].busy, vecs[i].idle, vecs[i].cr);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(outs()), 32'(vecs[i].exp));
      if (vecs[i].exp[7]) begin
        chk($sformatf("vec%0d_addr", i), 32'(bus.buf_addr), 32'(vecs[i].eaddr));
        chk($sformatf("vec%0d_data", i), bus.buf_wdata, vecs[i].sd);
      end
    end

    // Source stalls: len 3, src_valid 1,0,0,1,0,1
    pat = 6'b101001;
    nw  = 0;
    @(negedge clk); drive(1, 8'd3, 0, 32'h0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(0, 8'd0, pat[i], 32'hB0 + 32'(i), 0, 0, 0);
      #1;
      chk($sformatf("stall%0d_we", i), 32'(bus.buf_we), 32'(pat[i]));
      if (bus.buf_we) begin
        chk($sformatf("stall%0d_addr", i), 32'(bus.buf_addr), 32'(nw));
        nw++;
      end
    end
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 0, 0); #1;
    chk("stall_arm", 32'(bus.accel_data_ready), 32'h1);
    chk("stall_writes", 32'(nw), 32'd3);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 1, 0, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 0, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 1); #1;
    chk("stall_cpl", {29'h0, bus.cpl_valid, bus.cpl_status}, {29'h0, 1'b1, CPL_OK});
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0); #1;
    chk("stall_idle", 32'(bus.cmd_ready), 32'h1);

    // Completion backpressure on a len-1 job
    @(negedge clk); drive(1, 8'd1, 0, 32'h0,  0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hC0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hC0, 0, 0, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0,  1, 0, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0,  0, 0, 0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0,  0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0); #1;
      chk($sformatf("bp%0d_cpl", i), {29'h0, bus.cpl_valid, bus.cpl_status}, {29'h0, 1'b1, CPL_OK});
      chk($sformatf("bp%0d_cmd_ready", i), 32'(bus.cmd_ready), 32'h0);
    end
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 1); #1;
    chk("bp_release", 32'(bus.cpl_valid), 32'h1);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0); #1;
    chk("bp_idle", {30'h0, bus.cmd_ready, bus.cpl_valid}, 32'h2);

    // Timeout: accelerator never goes busy
    @(negedge clk); drive(1, 8'd1, 0, 32'h0,  0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hD0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hD0, 0, 0, 0);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 0, 0); #1;
      if (bus.cpl_valid) done = 1'b1;
      else if (bus.accel_data_ready) n++;
    end
    chk("tmo_reported", 32'(done), 32'h1);
    chk("tmo_arm_cycles_8_or_9", 32'((n == 8) || (n == 9)), 32'h1);
    chk("tmo_status", 32'(bus.cpl_status), 32'(CPL_TMO));
    chk("tmo_err", 32'(bus.err_timeout), 32'h1);
    chk("tmo_no_ack", 32'(bus.accel_ack), 32'h0);
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 0, 0); #1;
      chk($sformatf("tmo_hold%0d_cmd_ready", i), 32'(bus.cmd_ready), 32'h0);
    end
    @(negedge clk); drive(0, 8'd0, 0, 32'h0, 0, 1, 0); #1;
    chk("tmo_idle_ready", 32'(bus.cmd_ready), 32'h1);
    chk("tmo_err_sticky", 32'(bus.err_timeout), 32'h1);

    // Reset in the middle of LOAD, then a fresh job starts at address 0
    @(negedge clk); drive(1, 8'd4, 0, 32'h0,  0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hE0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hE0, 0, 0, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hE1, 0, 0, 0);
    @(negedge clk); reset_n = 1'b0; drive(0, 8'd0, 0, 32'h0, 0, 0, 0);
    @(negedge clk); #1;
    chk("rst_mid_outs", 32'(outs()), 32'h0);
    chk("rst_mid_addr", 32'(bus.buf_addr), 32'h0);
    chk("rst_mid_wdata", bus.buf_wdata, 32'h0);
    @(negedge clk); reset_n = 1'b1; drive(1, 8'd2, 0, 32'h0, 0, 1, 0); #1;
    chk("rst_new_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    @(negedge clk); drive(0, 8'd0, 1, 32'hF0, 0, 1, 0);
    @(negedge clk); drive(0, 8'd0, 1, 32'hF0, 0, 0, 0); #1;
    chk("rst_new_we", 32'(bus.buf_we), 32'h1);
    chk("rst_new_addr", 32'(bus.buf_addr), 32'h0);
    chk("rst_new_data", bus.buf_wdata, 32'hF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
